// File: rtl/brightness_input.sv
// Brightness level entry: three raw buttons (up, down, clear) adjust an 8-bit level with auto-repeat.
// Latency: level/upd change 2 (sync) + DEBOUNCE_CYC + 1 cycles after a clean raw button edge.
// Backpressure: none; level is a plain registered output and upd is a one-cycle change strobe.
module brightness_input #(
  parameter int          DEBOUNCE_CYC = 10000,
  parameter int          HOLD_CYC     = 500000,
  parameter int          REPEAT_CYC   = 100000,
  parameter logic [7:0]  STEP         = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_clr,
  output logic [7:0] level,
  output logic       upd
);

  // Button index within the per-button vectors.
  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_CLR = 2;

  // Debounce counter only has to reach DEBOUNCE_CYC-1.
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  // One timer serves both the hold delay and the repeat period.
  localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [2:0]    deb_prev_q;
  logic [DW-1:0] db_cnt_q [3];

  state_t        state_q;
  logic          dir_up_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    level_q;
  logic          upd_q;

  logic          up_ev;
  logic          dn_ev;
  logic          clr_ev;
  logic          up_ok;
  logic          dn_ok;
  logic          latched_hi;
  logic          opp_hi;
  logic          abort;
  logic [8:0]    sum9;
  logic [7:0]    up_lvl_d;
  logic [7:0]    dn_lvl_d;
  logic [7:0]    rep_lvl_d;

  assign raw   = {btn_clr, btn_dn, btn_up};
  assign level = level_q;
  assign upd   = upd_q;

  // Synchronize each raw button, then accept a new value only after it has held for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Press events, conflict filtering and saturating next-level candidates.
  always_comb begin
    up_ev      = deb_q[B_UP]  & ~deb_prev_q[B_UP];
    dn_ev      = deb_q[B_DN]  & ~deb_prev_q[B_DN];
    clr_ev     = deb_q[B_CLR] & ~deb_prev_q[B_CLR];
    // A press is ignored whenever the opposite button is also down (covers simultaneous presses).
    up_ok      = up_ev & ~deb_q[B_DN];
    dn_ok      = dn_ev & ~deb_q[B_UP];
    latched_hi = dir_up_q ? deb_q[B_UP] : deb_q[B_DN];
    opp_hi     = dir_up_q ? deb_q[B_DN] : deb_q[B_UP];
    abort      = ~latched_hi | opp_hi;
    sum9       = {1'b0, level_q} + {1'b0, STEP};
    up_lvl_d   = sum9[8] ? 8'hFF : sum9[7:0];
    dn_lvl_d   = (level_q < STEP) ? 8'h00 : (level_q - STEP);
    rep_lvl_d  = dir_up_q ? up_lvl_d : dn_lvl_d;
  end

  // Repeat FSM with registered level and change strobe; clear overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      dir_up_q <= 1'b0;
      timer_q  <= '0;
      level_q  <= 8'd0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (clr_ev) begin
        state_q <= IDLE;
        timer_q <= '0;
        if (level_q != 8'd0) begin
          level_q <= 8'd0;
          upd_q   <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (up_ok) begin
              state_q  <= HOLD;
              dir_up_q <= 1'b1;
              timer_q  <= '0;
              if (up_lvl_d != level_q) begin
                level_q <= up_lvl_d;
                upd_q   <= 1'b1;
              end
            end else if (dn_ok) begin
              state_q  <= HOLD;
              dir_up_q <= 1'b0;
              timer_q  <= '0;
              if (dn_lvl_d != level_q) begin
                level_q <= dn_lvl_d;
                upd_q   <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (abort) begin
              state_q <= IDLE;
              timer_q <= '0;
            end else if (timer_q == HOLD_LAST) begin
              state_q <= REPEAT;
              timer_q <= '0;
              if (rep_lvl_d != level_q) begin
                level_q <= rep_lvl_d;
                upd_q   <= 1'b1;
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          REPEAT: begin
            if (abort) begin
              state_q <= IDLE;
              timer_q <= '0;
            end else if (timer_q == REP_LAST) begin
              timer_q <= '0;
              if (rep_lvl_d != level_q) begin
                level_q <= rep_lvl_d;
                upd_q   <= 1'b1;
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brightness_input.sv
// Directed bench for brightness_input with short debounce/hold/repeat timing.
// Latency: expects level/upd 7 cycles after a raw edge (2 sync + 4 debounce + 1).
// Backpressure: none; upd pulses are counted on the falling edge.
module tb_brightness_input;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] level;
  logic       upd;

  int checks  = 0;
  int errors  = 0;
  int upd_cnt = 0;
  int base;
  int exp_lvl;

  always #5 clk = ~clk;

  brightness_input #(
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (20),
    .REPEAT_CYC   (5),
    .STEP         (8'd16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .btn_clr (btn_clr),
    .level   (level),
    .upd     (upd)
  );

  always @(negedge clk) begin
    if (upd) upd_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    btn_clr = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
  endtask

  // Short presses (no repeat): which = 0 up, 1 down.
  task automatic press(input int which, input int n);
    repeat (n) begin
      if (which == 0) btn_up = 1'b1;
      else            btn_dn = 1'b1;
      cyc(10);
      btn_up = 1'b0;
      btn_dn = 1'b0;
      cyc(10);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_level", level, 0);
    chk("rst_upd", upd, 0);
    chk("rst_state", int'(dut.state_q), 0);
    rst = 1'b1;
    cyc(2);

    // Single up press, exact latency and single pulse
    base   = upd_cnt;
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 6) chk("lat_pre", level, 0);
      if (i == 7) begin
        chk("lat_level", level, 16);
        chk("lat_upd", upd, 1);
      end
      if (i == 8) chk("lat_upd_drop", upd, 0);
    end
    btn_up = 1'b0;
    cyc(30);
    chk("rel_level", level, 16);
    chk("rel_pulses", upd_cnt - base, 1);

    // Glitchy button never debounces
    do_reset();
    base = upd_cnt;
    repeat (10) begin
      btn_up = 1'b1;
      cyc(2);
      btn_up = 1'b0;
      cyc(1);
    end
    cyc(10);
    chk("glitch_level", level, 0);
    chk("glitch_pulses", upd_cnt - base, 0);

    // Saturation at 255 with repeats
    do_reset();
    press(0, 15);
    chk("reach_240", level, 240);
    base   = upd_cnt;
    btn_up = 1'b1;
    for (int i = 1; i <= 47; i++) begin
      cyc(1);
      if (i == 7) chk("sat_hi_first", level, 255);
    end
    chk("sat_hi_level", level, 255);
    chk("sat_hi_pulses", upd_cnt - base, 1);
    btn_up = 1'b0;
    cyc(12);

    // Saturation at 0 with repeats
    do_reset();
    press(0, 1);
    chk("reach_16", level, 16);
    base   = upd_cnt;
    btn_dn = 1'b1;
    for (int i = 1; i <= 47; i++) begin
      cyc(1);
      if (i == 7) chk("sat_lo_first", level, 0);
    end
    chk("sat_lo_level", level, 0);
    chk("sat_lo_pulses", upd_cnt - base, 1);
    btn_dn = 1'b0;
    cyc(12);

    // Down hold from 128: press, hold expiry, repeat every 5, clamp
    do_reset();
    press(0, 8);
    chk("reach_128", level, 128);
    base    = upd_cnt;
    exp_lvl = 128;
    btn_dn  = 1'b1;
    for (int i = 1; i <= 67; i++) begin
      cyc(1);
      if (i == 7 || (i >= 27 && (i - 27) % 5 == 0))
        exp_lvl = (exp_lvl >= 16) ? exp_lvl - 16 : 0;
      chk($sformatf("rep_c%0d", i), level, exp_lvl);
    end
    chk("rep_pulses", upd_cnt - base, 8);
    btn_dn = 1'b0;
    cyc(12);
    chk("rep_idle", int'(dut.state_q), 0);
    chk("rep_final", level, 0);

    // Simultaneous up+down ignored
    do_reset();
    press(0, 2);
    chk("reach_32", level, 32);
    base   = upd_cnt;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    cyc(12);
    chk("both_level", level, 32);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cyc(12);
    chk("both_after", level, 32);
    chk("both_pulses", upd_cnt - base, 0);

    // Clear while up held aborts repeat
    base   = upd_cnt;
    btn_up = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      if (i == 7)  chk("clr_up_step", level, 48);
      if (i == 10) btn_clr = 1'b1;
      if (i == 16) chk("clr_pre", level, 48);
      if (i == 17) begin
        chk("clr_level", level, 0);
        chk("clr_upd", upd, 1);
      end
      if (i == 20) btn_clr = 1'b0;
    end
    chk("clr_hold_level", level, 0);
    chk("clr_idle", int'(dut.state_q), 0);
    chk("clr_pulses", upd_cnt - base, 2);
    btn_up = 1'b0;
    cyc(12);

    // Reset mid-REPEAT, then held button gives one step after release
    do_reset();
    press(0, 3);
    chk("reach_48", level, 48);
    btn_up = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      cyc(1);
      if (i == 27) chk("mid_rep_80", level, 80);
    end
    chk("mid_rep_state", int'(dut.state_q), 2);
    rst = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_upd", upd, 0);
    chk("arst_state", int'(dut.state_q), 0);
    cyc(3);
    base = upd_cnt;
    rst  = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      if (j == 6) chk("post_rst_pre", level, 0);
      if (j == 7) begin
        chk("post_rst_level", level, 16);
        chk("post_rst_upd", upd, 1);
      end
    end
    btn_up = 1'b0;
    cyc(12);
    chk("post_rst_final", level, 16);
    chk("post_rst_pulses", upd_cnt - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
